// File: rtl/booth_acc_reg.sv
// -----------------------------------------------------------------------------
// booth_acc_reg
//
// Accumulator (A) register for a shift-add / Booth multiplier datapath.
// Supports radix-2 (shift by 1) and radix-4 (shift by 2) operation. It can
// clear, load the adder result, shift arithmetically right, or load and shift
// in the same cycle. The bits shifted out are kept for the Q-register chain.
// A counter tracks shifts since the last clear and flags the final iteration.
//
// Parameters
//   WIDTH   accumulator width (even, >= 4)
//   RADIX4  0: radix-2 (SH=1), 1: radix-4 (SH=2)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_b      in   1      asynchronous active-low reset
//   c0         in   1      clear q, a_lsb, shift_cnt, last (highest priority)
//   c2         in   1      load q from sum
//   c4         in   1      arithmetic shift right by SH (of sum when c2=1)
//   c6         in   1      enable obus driver
//   sum        in   WIDTH  adder result
//   q          out  WIDTH  accumulator contents (registered)
//   a_lsb      out  SH     bits shifted out by the last shift (registered)
//   obus       out  WIDTH  tri-state copy of q, driven while c6=1
//   shift_cnt  out  CW     shifts since last clear, saturating at ITER
//   last       out  1      shift_cnt == ITER (registered)
// -----------------------------------------------------------------------------
module booth_acc_reg #(
   parameter  int WIDTH  = 8,
   parameter  int RADIX4 = 0,
   localparam int SH     = 1 + RADIX4,
   localparam int ITER   = WIDTH / SH,
   localparam int CW     = $clog2(ITER + 1)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             c0,
   input  logic             c2,
   input  logic             c4,
   input  logic             c6,
   input  logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] q,
   output logic [SH-1:0]    a_lsb,
   output logic [WIDTH-1:0] obus,
   output logic [CW-1:0]    shift_cnt,
   output logic             last
);

   // Terminal count in the counter's own width.
   localparam logic [CW-1:0] ITER_C = CW'(ITER);

   logic [WIDTH-1:0] q_d,     q_q;
   logic [SH-1:0]    a_lsb_d, a_lsb_q;
   logic [CW-1:0]    cnt_d,   cnt_q;
   logic             last_d,  last_q;

   logic [WIDTH-1:0] shift_src_s;
   logic [WIDTH-1:0] shifted_s;
   logic [CW-1:0]    cnt_inc_s;

   // Arithmetic shift right by SH; the sign bit fills the vacated upper bits.
   function automatic logic [WIDTH-1:0] asr_f(input logic [WIDTH-1:0] v);
      return $unsigned($signed(v) >>> SH);
   endfunction

   // Shift source selection: a fused load-shift operates on sum, not on q.
   always_comb begin
      shift_src_s = q_q;
      if (c2) begin
         shift_src_s = sum;
      end else begin
         shift_src_s = q_q;
      end
   end

   assign shifted_s = asr_f(shift_src_s);

   // Saturating increment: extra shifts after the last iteration keep the count.
   always_comb begin
      cnt_inc_s = cnt_q;
      if (cnt_q == ITER_C) begin
         cnt_inc_s = cnt_q;
      end else begin
         cnt_inc_s = cnt_q + CW'(1);
      end
   end

   // Next-state logic: clear dominates, then load/shift; otherwise hold.
   always_comb begin
      q_d     = q_q;
      a_lsb_d = a_lsb_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (c0) begin
         q_d     = '0;
         a_lsb_d = '0;
         cnt_d   = '0;
         last_d  = 1'b0;
      end else begin
         case ({c2, c4})
            2'b10: begin
               q_d = sum;
            end
            2'b01, 2'b11: begin
               q_d     = shifted_s;
               a_lsb_d = shift_src_s[SH-1:0];
               cnt_d   = cnt_inc_s;
               last_d  = (cnt_inc_s == ITER_C);
            end
            default: begin
               q_d     = q_q;
               a_lsb_d = a_lsb_q;
               cnt_d   = cnt_q;
               last_d  = last_q;
            end
         endcase
      end
   end

   // State registers with asynchronous reset; reset aborts any sequence.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q_q     <= '0;
         a_lsb_q <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         a_lsb_q <= a_lsb_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign q         = q_q;
   assign a_lsb     = a_lsb_q;
   assign shift_cnt = cnt_q;
   assign last      = last_q;

   // Bus driver reflects the current register value; it never feeds back.
   assign obus = c6 ? q_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_booth_acc_reg.sv
// -----------------------------------------------------------------------------
// tb_booth_acc_reg
//
// Drives one radix-2 and one radix-4 instance (WIDTH=8) with identical
// commands and compares both against a behavioural model that works on
// signed integers: a shift is floor division by 2**SH, and the shifted-out
// bits are the value modulo 2**SH. The obus nets carry pull-ups, so an
// undriven bus reads back as all ones.
// -----------------------------------------------------------------------------
module tb_booth_acc_reg;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       c0, c2, c4, c6;
   logic [7:0] sum;

   logic [7:0] q2, q4;
   logic       a2;
   logic [1:0] a4;
   logic [3:0] cnt2;
   logic [2:0] cnt4;
   logic       last2, last4;
   wire  [7:0] obus2, obus4;

   int vectors     = 0;
   int miscompares = 0;

   // Model state, index 0 = radix-2, index 1 = radix-4.
   int mq[2];
   int ma[2];
   int mc[2];

   always #5 clk = ~clk;

   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (obus2[i]);
      pullup (obus4[i]);
   end

   booth_acc_reg #(.WIDTH(8), .RADIX4(0)) dut2 (
      .clk(clk), .rst_b(rst_b), .c0(c0), .c2(c2), .c4(c4), .c6(c6),
      .sum(sum), .q(q2), .a_lsb(a2), .obus(obus2),
      .shift_cnt(cnt2), .last(last2)
   );

   booth_acc_reg #(.WIDTH(8), .RADIX4(1)) dut4 (
      .clk(clk), .rst_b(rst_b), .c0(c0), .c2(c2), .c4(c4), .c6(c6),
      .sum(sum), .q(q4), .a_lsb(a4), .obus(obus4),
      .shift_cnt(cnt4), .last(last4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 2; r++) begin
         mq[r] = 0;
         ma[r] = 0;
         mc[r] = 0;
      end
   endtask

   // One rising edge of the specification's rules on integers.
   task automatic model_edge();
      for (int r = 0; r < 2; r++) begin
         int sh, iter, src, s;
         sh   = r + 1;
         iter = 8 / sh;
         if (c0) begin
            mq[r] = 0; ma[r] = 0; mc[r] = 0;
         end else if (c4) begin
            src = c2 ? int'(sum) : mq[r];
            s   = (src > 127) ? src - 256 : src;
            ma[r] = src % (1 << sh);
            mq[r] = (s >>> sh) & 255;
            mc[r] = (mc[r] < iter) ? mc[r] + 1 : iter;
         end else if (c2) begin
            mq[r] = int'(sum);
         end
      end
   endtask

   function automatic logic [31:0] exp_bus(input int r);
      return c6 ? 32'(mq[r]) : 32'h0000_00FF;
   endfunction

   task automatic check_bus(input string tag);
      check({tag, ".obus2"}, 32'(obus2), exp_bus(0));
      check({tag, ".obus4"}, 32'(obus4), exp_bus(1));
   endtask

   task automatic check_all(input string tag);
      check({tag, ".q2"},    32'(q2),    32'(mq[0]));
      check({tag, ".a2"},    32'(a2),    32'(ma[0]));
      check({tag, ".cnt2"},  32'(cnt2),  32'(mc[0]));
      check({tag, ".last2"}, 32'(last2), 32'(mc[0] == 8));
      check({tag, ".q4"},    32'(q4),    32'(mq[1]));
      check({tag, ".a4"},    32'(a4),    32'(ma[1]));
      check({tag, ".cnt4"},  32'(cnt4),  32'(mc[1]));
      check({tag, ".last4"}, 32'(last4), 32'(mc[1] == 4));
      check_bus(tag);
   endtask

   // Apply one command set: bus checked before the edge, everything after.
   task automatic cyc(input string tag, input logic i0, input logic i2,
                      input logic i4, input logic i6, input logic [7:0] isum);
      @(negedge clk);
      c0 = i0; c2 = i2; c4 = i4; c6 = i6; sum = isum;
      #1;
      check_bus({tag, ".pre"});
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_b = 1'b1;
      c0 = 1'b0; c2 = 1'b0; c4 = 1'b0; c6 = 1'b0; sum = 8'h00;

      // Reset asserted mid-clock, before any edge.
      #2 rst_b = 1'b0;
      model_reset();
      #1 check_all("rst");
      c6 = 1'b1;
      #1 check_bus("rst_c6");
      @(posedge clk);
      #1 check_all("rst_hold");
      @(negedge clk);
      rst_b = 1'b1;
      c6 = 1'b0;

      // Radix-2 load then shift.
      cyc("load_a5", 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
      check("load_a5.q2_const", 32'(q2), 32'h0000_00A5);
      cyc("shift_a5", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      check("shift_a5.q2_const", 32'(q2), 32'h0000_00D2);
      check("shift_a5.a2_const", 32'(a2), 32'h0000_0001);

      // Fused load-shift.
      cyc("fused_7e", 1'b0, 1'b1, 1'b1, 1'b0, 8'h7E);
      check("fused_7e.q2_const", 32'(q2), 32'h0000_003F);
      check("fused_7e.cnt2_const", 32'(cnt2), 32'h0000_0002);

      // Radix-4 shifts and saturation.
      cyc("clr_r4", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc("load_96", 1'b0, 1'b1, 1'b0, 1'b1, 8'h96);
      cyc("r4_sh1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("r4_sh1.q4_const", 32'(q4), 32'h0000_00E5);
      check("r4_sh1.a4_const", 32'(a4), 32'h0000_0002);
      for (int i = 2; i <= 5; i++) cyc($sformatf("r4_sh%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("r4_sat.cnt4_const", 32'(cnt4), 32'h0000_0004);
      check("r4_sat.last4_const", 32'(last4), 32'h0000_0001);

      // Radix-2 count to ITER and saturation.
      cyc("clr_r2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc("load_c3", 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
      for (int i = 1; i <= 9; i++) cyc($sformatf("r2_sh%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      check("r2_sat.cnt2_const", 32'(cnt2), 32'h0000_0008);
      check("r2_sat.last2_const", 32'(last2), 32'h0000_0001);

      // All commands at once: clear wins.
      cyc("all_cmd", 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
      check("all_cmd.q2_const", 32'(q2), 32'h0000_0000);

      // Reset in the middle of a shift sequence, then normal operation.
      cyc("mid_load", 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B);
      for (int i = 1; i <= 3; i++) cyc($sformatf("mid_sh%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      #2;
      c0 = 1'b0; c2 = 1'b0; c4 = 1'b0; c6 = 1'b0;
      rst_b = 1'b0;
      model_reset();
      #1 check_all("mid_rst");
      @(negedge clk);
      rst_b = 1'b1;
      cyc("post_rst", 1'b0, 1'b1, 1'b1, 1'b0, 8'h81);

      // Bus toggling with no register change.
      cyc("bus_load", 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
      for (int i = 0; i < 4; i++) begin
         c6 = ~c6;
         #1 check_bus($sformatf("bus_tog%0d", i));
      end
      cyc("bus_hold1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      cyc("bus_hold0", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);

      // Randomized command mix.
      for (int i = 0; i < 300; i++) begin
         logic r0;
         r0 = ($urandom_range(0, 15) == 0);
         cyc($sformatf("rnd%0d", i), r0, 1'($urandom), 1'($urandom),
             1'($urandom), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
